// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute ALU and its issue controller.
//   - 10-bit ALU opcodes {funct3, opcode[6:0]} as consumed by the ALU
//   - major opcode (op7) constants and the M-extension funct7 value
//   - op_class_t: how the issue controller sequences an instruction
//   - state_t: issue controller states
package alu_pkg;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OP            = 7'b0110011;
    localparam logic [6:0] OP32          = 7'b0111011;
    localparam logic [6:0] SYSTEM        = 7'b1110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Register-register ALU ops (funct7 distinguishes ADD/SUB, SRL/SRA)
    localparam logic [9:0] OPC_ADD    = 10'h033;
    localparam logic [9:0] OPC_SLL    = 10'h0b3;
    localparam logic [9:0] OPC_SLT    = 10'h133;
    localparam logic [9:0] OPC_SLTU   = 10'h1b3;
    localparam logic [9:0] OPC_XOR    = 10'h233;
    localparam logic [9:0] OPC_SRL    = 10'h2b3;
    localparam logic [9:0] OPC_OR     = 10'h333;
    localparam logic [9:0] OPC_AND    = 10'h3b3;

    // Register-immediate ALU ops
    localparam logic [9:0] OPC_ADDI   = 10'h013;
    localparam logic [9:0] OPC_SLLI   = 10'h093;
    localparam logic [9:0] OPC_SLTI   = 10'h113;
    localparam logic [9:0] OPC_SLTIU  = 10'h193;
    localparam logic [9:0] OPC_XORI   = 10'h213;
    localparam logic [9:0] OPC_SRLI   = 10'h293;
    localparam logic [9:0] OPC_ORI    = 10'h313;
    localparam logic [9:0] OPC_ANDI   = 10'h393;

    // M extension (with funct7 = FUNCT7_MULDIV)
    localparam logic [9:0] OPC_MUL    = 10'h033;
    localparam logic [9:0] OPC_MULH   = 10'h0b3;
    localparam logic [9:0] OPC_MULHSU = 10'h133;
    localparam logic [9:0] OPC_MULHU  = 10'h1b3;
    localparam logic [9:0] OPC_DIV    = 10'h233;
    localparam logic [9:0] OPC_DIVU   = 10'h2b3;
    localparam logic [9:0] OPC_REM    = 10'h333;
    localparam logic [9:0] OPC_REMU   = 10'h3b3;
    localparam logic [9:0] OPC_MULW   = 10'h03b;
    localparam logic [9:0] OPC_DIVW   = 10'h23b;
    localparam logic [9:0] OPC_DIVUW  = 10'h2bb;
    localparam logic [9:0] OPC_REMW   = 10'h33b;
    localparam logic [9:0] OPC_REMUW  = 10'h3bb;

    // SYSTEM, funct3 = 0; imm12 selects ECALL (0) versus EBREAK (1)
    localparam logic [9:0] OPC_ECALL  = 10'h073;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MUL,
        CLS_DIV,
        CLS_ECALL
    } op_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_HALT
    } state_t;

    // True for any OP/OP32 encoding carrying the M-extension funct7
    function automatic logic is_muldiv(input logic [6:0] op7, input logic [6:0] funct7);
        return ((op7 == OP) || (op7 == OP32)) && (funct7 == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/alu_op_classify.sv
// alu_op_classify: purely combinational instruction classifier, shared with
// decode.
//   opcode  in  10  {funct3, opcode[6:0]}
//   funct7  in  7   instruction[31:25]
//   imm12   in  12  instruction[31:20]
//   op_class out    CLS_MUL / CLS_DIV for M-extension ops (funct3 bit 2 splits
//                   multiply from divide/remainder), CLS_ECALL for ECALL,
//                   CLS_ALU otherwise
module alu_op_classify
    import alu_pkg::*;
(
    input  logic [9:0]  opcode,
    input  logic [6:0]  funct7,
    input  logic [11:0] imm12,
    output op_class_t   op_class
);

    logic [6:0] op7;
    logic [2:0] funct3;

    assign op7    = opcode[6:0];
    assign funct3 = opcode[9:7];

    always_comb begin
        op_class = CLS_ALU;
        if (is_muldiv(op7, funct7)) begin
            op_class = funct3[2] ? CLS_DIV : CLS_MUL;
        end else if ((opcode == OPC_ECALL) && (imm12 == '0)) begin
            op_class = CLS_ECALL;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/sequencing controller between decode and the ALU.
// One instruction in flight at a time. Single-cycle ops complete the cycle
// after accept; multiply/divide hold the pipeline for MUL_LAT/DIV_LAT cycles.
// ECALL drains and then halts issue until a flush.
//   clk, reset        clock, asynchronous active-high reset
//   in_valid/in_ready decode handshake (in_ready is combinational)
//   in_opcode, in_funct7, in_imm12, in_rd   decoded instruction fields
//   flush             redirect; kills the in-flight op, highest priority
//   out_valid/out_ready writeback handshake; out_rd, out_ecall qualify it
//   alu_issue         operands launched into the ALU this cycle
//   busy_rd, busy_rd_valid  in-flight destination for hazard checks
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_opcode,
    input  logic [6:0]  in_funct7,
    input  logic [11:0] in_imm12,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic        out_ecall,
    output logic        alu_issue,
    output logic [4:0]  busy_rd,
    output logic        busy_rd_valid
);

    // Counter preload: one cycle is spent on the accept edge and one on the
    // BUSY->DONE edge, so LAT-2 decrements land out_valid exactly LAT cycles
    // after accept.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    op_class_t        in_class;
    logic             accept;

    // Next-state values for an accepted instruction
    state_t           issue_state;
    logic [CNT_W-1:0] issue_cnt;
    logic             issue_out_valid;

    alu_op_classify u_classify (
        .opcode   (in_opcode),
        .funct7   (in_funct7),
        .imm12    (in_imm12),
        .op_class (in_class)
    );

    // A completing ECALL never frees the slot, so nothing issues behind it.
    assign in_ready  = ((state == ST_IDLE) ||
                        ((state == ST_DONE) && out_ready && !out_ecall))
                       && !flush && !reset;
    assign accept    = in_valid && in_ready;
    assign alu_issue = accept;

    always_comb begin
        issue_state     = ST_DONE;
        issue_cnt       = '0;
        issue_out_valid = 1'b1;
        case (in_class)
            CLS_MUL: begin
                issue_state     = ST_BUSY;
                issue_cnt       = MUL_CNT;
                issue_out_valid = 1'b0;
            end
            CLS_DIV: begin
                issue_state     = ST_BUSY;
                issue_cnt       = DIV_CNT;
                issue_out_valid = 1'b0;
            end
            default: begin
                issue_state     = ST_DONE;
                issue_cnt       = '0;
                issue_out_valid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            out_valid     <= 1'b0;
            out_rd        <= '0;
            out_ecall     <= 1'b0;
            busy_rd       <= '0;
            busy_rd_valid <= 1'b0;
        end else if (flush) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            out_valid     <= 1'b0;
            out_rd        <= '0;
            out_ecall     <= 1'b0;
            busy_rd       <= '0;
            busy_rd_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state         <= issue_state;
                        cnt           <= issue_cnt;
                        out_valid     <= issue_out_valid;
                        out_rd        <= in_rd;
                        out_ecall     <= (in_class == CLS_ECALL);
                        busy_rd       <= in_rd;
                        busy_rd_valid <= (in_rd != '0);
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            state         <= issue_state;
                            cnt           <= issue_cnt;
                            out_valid     <= issue_out_valid;
                            out_rd        <= in_rd;
                            out_ecall     <= (in_class == CLS_ECALL);
                            busy_rd       <= in_rd;
                            busy_rd_valid <= (in_rd != '0);
                        end else begin
                            state         <= out_ecall ? ST_HALT : ST_IDLE;
                            out_valid     <= 1'b0;
                            busy_rd       <= '0;
                            busy_rd_valid <= 1'b0;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed test of alu_issue_ctrl with MUL_LAT=4 and
// DIV_LAT=34. Inputs change 1 time unit after the rising edge; outputs are
// checked at least 1 time unit after that.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_opcode;
    logic [6:0]  in_funct7;
    logic [11:0] in_imm12;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_ecall;
    logic        alu_issue;
    logic [4:0]  busy_rd;
    logic        busy_rd_valid;

    int n_chk  = 0;
    int n_fail = 0;
    int seen;

    alu_issue_ctrl #(
        .MUL_LAT (4),
        .DIV_LAT (34),
        .CNT_W   (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct7     (in_funct7),
        .in_imm12      (in_imm12),
        .in_rd         (in_rd),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rd        (out_rd),
        .out_ecall     (out_ecall),
        .alu_issue     (alu_issue),
        .busy_rd       (busy_rd),
        .busy_rd_valid (busy_rd_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] opc, input logic [6:0] f7,
                         input logic [11:0] imm, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_opcode = opc;
        in_funct7 = f7;
        in_imm12  = imm;
        in_rd     = rd;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_funct7 = '0;
        in_imm12  = '0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #2;
        in_valid = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_ecall", out_ecall, 0);
        chk("rst_busy_rd", busy_rd, 0);
        chk("rst_busy_rd_valid", busy_rd_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_alu_issue", alu_issue, 0);
        in_valid = 1'b0;
        tick();
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;

        // ADDI back-to-back, full throughput
        drive(OPC_ADDI, 7'd0, 12'h005, 5'd1);
        #1;
        chk("addi1_in_ready", in_ready, 1);
        chk("addi1_issue", alu_issue, 1);
        tick();
        chk("addi1_out_valid", out_valid, 1);
        chk("addi1_out_rd", out_rd, 1);
        chk("addi1_busy_rd", busy_rd, 1);
        chk("addi1_busy_rd_valid", busy_rd_valid, 1);
        in_rd = 5'd2;
        #1;
        chk("addi2_in_ready", in_ready, 1);
        tick();
        chk("addi2_out_valid", out_valid, 1);
        chk("addi2_out_rd", out_rd, 2);
        in_rd = 5'd3;
        #1;
        chk("addi3_in_ready", in_ready, 1);
        tick();
        chk("addi3_out_valid", out_valid, 1);
        chk("addi3_out_rd", out_rd, 3);
        in_valid = 1'b0;
        #1;
        chk("addi3_done_in_ready", in_ready, 1);
        tick();
        chk("addi_idle_out_valid", out_valid, 0);
        chk("addi_idle_busy_rd_valid", busy_rd_valid, 0);
        chk("addi_idle_busy_rd", busy_rd, 0);

        // MUL: busy for 3 cycles, out_valid 4 cycles after accept
        drive(OPC_MUL, FUNCT7_MULDIV, 12'h000, 5'd7);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mul_busy_in_ready", in_ready, 0);
            chk("mul_busy_out_valid", out_valid, 0);
            chk("mul_busy_rd", busy_rd, 7);
            chk("mul_busy_rd_valid", busy_rd_valid, 1);
            tick();
        end
        chk("mul_out_valid", out_valid, 1);
        chk("mul_out_rd", out_rd, 7);
        chk("mul_out_ecall", out_ecall, 0);
        chk("mul_done_in_ready", in_ready, 1);
        tick();
        chk("mul_idle_out_valid", out_valid, 0);

        // DIVW: out_valid exactly 34 cycles after accept
        drive(OPC_DIVW, FUNCT7_MULDIV, 12'h000, 5'd9);
        tick();
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 33; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("divw_early_valid_cycles", seen, 0);
        chk("divw_out_valid", out_valid, 1);
        chk("divw_out_rd", out_rd, 9);
        tick();
        chk("divw_idle_out_valid", out_valid, 0);

        // DIVU with writeback stalled for 5 cycles
        out_ready = 1'b0;
        drive(OPC_DIVU, FUNCT7_MULDIV, 12'h000, 5'd12);
        tick();
        in_valid = 1'b0;
        repeat (33) tick();
        chk("divu_out_valid", out_valid, 1);
        chk("divu_out_rd", out_rd, 12);
        drive(OPC_ADDI, 7'd0, 12'h001, 5'd13);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("divu_stall_out_valid", out_valid, 1);
            chk("divu_stall_out_rd", out_rd, 12);
            chk("divu_stall_in_ready", in_ready, 0);
            chk("divu_stall_issue", alu_issue, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("divu_release_in_ready", in_ready, 1);
        chk("divu_release_issue", alu_issue, 1);
        chk("divu_release_out_rd", out_rd, 12);
        tick();
        chk("b2b_out_valid", out_valid, 1);
        chk("b2b_out_rd", out_rd, 13);
        in_valid = 1'b0;
        tick();
        chk("b2b_idle_out_valid", out_valid, 0);

        // Flush 10 cycles into a DIV
        drive(OPC_DIV, FUNCT7_MULDIV, 12'h000, 5'd5);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("flush_pre_busy_rd_valid", busy_rd_valid, 1);
        flush = 1'b1;
        drive(OPC_ADDI, 7'd0, 12'h000, 5'd6);
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_issue", alu_issue, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_post_out_valid", out_valid, 0);
        chk("flush_post_busy_rd_valid", busy_rd_valid, 0);
        chk("flush_post_busy_rd", busy_rd, 0);
        chk("flush_post_in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            tick();
        end
        chk("flush_killed_valid_cycles", seen, 0);

        // EBREAK (imm12=1) is plain ALU class: no halt; rd=0 never busy
        drive(OPC_ECALL, 7'd0, 12'h001, 5'd0);
        tick();
        in_valid = 1'b0;
        chk("ebreak_out_valid", out_valid, 1);
        chk("ebreak_out_ecall", out_ecall, 0);
        chk("ebreak_busy_rd_valid", busy_rd_valid, 0);
        tick();
        chk("ebreak_idle_out_valid", out_valid, 0);
        chk("ebreak_idle_in_ready", in_ready, 1);

        // ECALL: completes, then halts issue until flush
        drive(OPC_ECALL, 7'd0, 12'h000, 5'd0);
        tick();
        chk("ecall_out_valid", out_valid, 1);
        chk("ecall_out_ecall", out_ecall, 1);
        drive(OPC_ADDI, 7'd0, 12'h000, 5'd3);
        #1;
        chk("ecall_done_in_ready", in_ready, 0);
        chk("ecall_done_issue", alu_issue, 0);
        tick();
        chk("halt_out_valid", out_valid, 0);
        chk("halt_in_ready", in_ready, 0);
        repeat (3) tick();
        chk("halt_hold_in_ready", in_ready, 0);
        chk("halt_hold_out_valid", out_valid, 0);
        flush = 1'b1;
        #1;
        chk("halt_flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("halt_exit_in_ready", in_ready, 1);
        chk("halt_exit_issue", alu_issue, 1);
        tick();
        chk("halt_exit_out_valid", out_valid, 1);
        chk("halt_exit_out_rd", out_rd, 3);
        chk("halt_exit_out_ecall", out_ecall, 0);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset mid-BUSY
        drive(OPC_MULW, FUNCT7_MULDIV, 12'h000, 5'd8);
        tick();
        in_valid = 1'b0;
        chk("areset_pre_busy_rd", busy_rd, 8);
        chk("areset_pre_busy_rd_valid", busy_rd_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_busy_rd_valid", busy_rd_valid, 0);
        chk("areset_busy_rd", busy_rd, 0);
        chk("areset_in_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("areset_release_in_ready", in_ready, 1);
        seen = 0;
        repeat (5) begin
            if (out_valid) seen++;
            tick();
        end
        chk("areset_killed_valid_cycles", seen, 0);
        drive(OPC_ADDI, 7'd0, 12'h010, 5'd4);
        tick();
        in_valid = 1'b0;
        chk("resume_out_valid", out_valid, 1);
        chk("resume_out_rd", out_rd, 4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
